axis_slice_array_p: RTL

- Parametrised register-slice pipeline for one AXI4-Stream or meta channel. It replaces the fixed-width, per-channel slice IP instances used in the RDMA/network slicing arrays.
- Generalises data width, stage count and stage mode (full skid, forward-only, bypass). Adds beat-occupancy and in-flight-packet counters for drain and idle detection.
- Sits between network stack and user logic; one instance per channel.

---
 rtl/axis_slice_array_p_pkg.sv | 21 ++
 rtl/axis_slice_array_p_stage.sv | 87 ++++++++
 rtl/axis_slice_array_p.sv | 115 +++++++++++
 3 files changed

// File: rtl/axis_slice_array_p_pkg.sv
// Shared types for the parametrised AXI4-Stream register-slice array.
package lynxTypes;

    typedef enum logic [1:0] {
        SLICE_FULL,
        SLICE_FWD,
        SLICE_BYPASS
    } slice_mode_t;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Counter width; never below 1 so bypass builds with N_STAGES=0 still elaborate.
    function automatic int occ_bits(input int n_stages);
        int b;
        b = $clog2(2 * n_stages + 1);
        return (b < 1) ? 1 : b;
    endfunction

endpackage

// File: rtl/axis_slice_array_p_stage.sv
// One register-slice stage carrying a flat {tlast, tkeep, tdata} payload.
module axis_slice_stage
    import lynxTypes::*;
#(
    parameter int          DATA_BITS = 512,
    parameter slice_mode_t MODE      = SLICE_FULL,
    localparam int         PW        = DATA_BITS + DATA_BITS / 8 + 1
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [PW-1:0] s_payload,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [PW-1:0] m_payload
);

    if (MODE == SLICE_FULL) begin : g_full
        logic [1:0]    st_q, st_d;
        logic [PW-1:0] main_q, skid_q;
        logic          rdy_q;
        logic          in_acc, out_acc;

        assign in_acc  = s_valid & rdy_q;
        assign out_acc = (st_q != ST_EMPTY) & m_ready;

        always_comb begin
            st_d = st_q;
            case (st_q)
                ST_EMPTY: if (in_acc) st_d = ST_ONE;
                ST_ONE: begin
                    if (in_acc && !out_acc)      st_d = ST_TWO;
                    else if (!in_acc && out_acc) st_d = ST_EMPTY;
                end
                ST_TWO:   if (out_acc) st_d = ST_ONE;
                default:  st_d = ST_EMPTY;
            endcase
        end

        // Ready is a pure register: it looks at the next state, never at m_ready.
        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                st_q   <= ST_EMPTY;
                main_q <= '0;
                skid_q <= '0;
                rdy_q  <= 1'b0;
            end else begin
                st_q  <= st_d;
                rdy_q <= (st_d != ST_TWO);
                if (st_q == ST_TWO) begin
                    if (out_acc) main_q <= skid_q;
                end else if (in_acc) begin
                    if (st_q == ST_EMPTY || out_acc) main_q <= s_payload;
                    else                             skid_q <= s_payload;
                end
            end
        end

        assign s_ready   = rdy_q;
        assign m_valid   = (st_q != ST_EMPTY);
        assign m_payload = main_q;
    end else if (MODE == SLICE_FWD) begin : g_fwd
        logic          vld_q;
        logic [PW-1:0] dat_q;

        assign s_ready = !vld_q | m_ready;

        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else if (s_ready) begin
                vld_q <= s_valid;
                if (s_valid) dat_q <= s_payload;
            end
        end

        assign m_valid   = vld_q;
        assign m_payload = dat_q;
    end else begin : g_wire
        assign s_ready   = m_ready;
        assign m_valid   = s_valid;
        assign m_payload = s_payload;
    end

endmodule

// File: rtl/axis_slice_array_p.sv
// Chain of N_STAGES slice stages for one stream channel, with beat and packet
// occupancy counters for drain/idle detection.
module axis_slice_array_p
    import lynxTypes::*;
#(
    parameter int          DATA_BITS     = 512,
    parameter int          N_STAGES      = 2,
    parameter slice_mode_t MODE          = SLICE_FULL,
    parameter bit          HAS_KEEP_LAST = 1'b1,
    localparam int         KEEP_BITS     = DATA_BITS / 8,
    localparam int         OCC_BITS      = occ_bits(N_STAGES)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [DATA_BITS-1:0] s_axis_tdata,
    input  logic [KEEP_BITS-1:0] s_axis_tkeep,
    input  logic                 s_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic [KEEP_BITS-1:0] m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic [OCC_BITS-1:0]  occupancy,
    output logic [OCC_BITS-1:0]  pkts_inflight,
    output logic                 idle
);

    localparam int PW = DATA_BITS + KEEP_BITS + 1;

    logic [KEEP_BITS-1:0] keep_in;
    logic                 last_in;

    // Meta channels treat every beat as a complete, fully-enabled packet.
    assign keep_in = HAS_KEEP_LAST ? s_axis_tkeep : '1;
    assign last_in = HAS_KEEP_LAST ? s_axis_tlast : 1'b1;

    if (MODE == SLICE_BYPASS) begin : g_bypass
        assign m_axis_tvalid = s_axis_tvalid;
        assign s_axis_tready = m_axis_tready;
        assign m_axis_tdata  = s_axis_tdata;
        assign m_axis_tkeep  = keep_in;
        assign m_axis_tlast  = last_in;
        assign occupancy     = '0;
        assign pkts_inflight = '0;
        assign idle          = 1'b1;
    end else begin : g_pipe
        logic                      run_q;
        logic [N_STAGES:0]         vld_pipe;
        logic [N_STAGES:0]         rdy_pipe;
        logic [N_STAGES:0][PW-1:0] pl_pipe;
        logic                      in_acc, out_acc, in_pkt, out_pkt;
        logic [OCC_BITS-1:0]       occ_q, pkt_q;

        // Holds the input closed for the reset cycle even when a forward
        // stage would otherwise pass m_axis_tready straight through.
        always_ff @(posedge aclk) begin
            if (!aresetn) run_q <= 1'b0;
            else          run_q <= 1'b1;
        end

        assign vld_pipe[0]        = s_axis_tvalid & run_q;
        assign pl_pipe[0]         = {last_in, keep_in, s_axis_tdata};
        assign s_axis_tready      = rdy_pipe[0] & run_q;
        assign rdy_pipe[N_STAGES] = m_axis_tready;

        for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
            axis_slice_stage #(
                .DATA_BITS (DATA_BITS),
                .MODE      (MODE)
            ) u_stage (
                .aclk      (aclk),
                .aresetn   (aresetn),
                .s_valid   (vld_pipe[i]),
                .s_ready   (rdy_pipe[i]),
                .s_payload (pl_pipe[i]),
                .m_valid   (vld_pipe[i+1]),
                .m_ready   (rdy_pipe[i+1]),
                .m_payload (pl_pipe[i+1])
            );
        end

        assign m_axis_tvalid = vld_pipe[N_STAGES];
        assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = pl_pipe[N_STAGES];

        assign in_acc  = s_axis_tvalid & s_axis_tready;
        assign out_acc = m_axis_tvalid & m_axis_tready;
        assign in_pkt  = in_acc & last_in;
        assign out_pkt = out_acc & m_axis_tlast;

        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                occ_q <= '0;
                pkt_q <= '0;
            end else begin
                case ({in_acc, out_acc})
                    2'b10:   occ_q <= occ_q + OCC_BITS'(1);
                    2'b01:   occ_q <= occ_q - OCC_BITS'(1);
                    default: occ_q <= occ_q;
                endcase
                case ({in_pkt, out_pkt})
                    2'b10:   pkt_q <= pkt_q + OCC_BITS'(1);
                    2'b01:   pkt_q <= pkt_q - OCC_BITS'(1);
                    default: pkt_q <= pkt_q;
                endcase
            end
        end

        assign occupancy     = occ_q;
        assign pkts_inflight = pkt_q;
        assign idle          = (occ_q == '0);
    end

endmodule
